// File: rtl/tcp_rx_ctrl.sv
// Receive-side TCP control engine: reads per-flow state for one inbound header,
// decides in-order acceptance and ACK advancement, emits payload, writes back, requests an ACK.
module tcp_rx_ctrl #(
    parameter int unsigned FLOWID_W = 8,
    parameter int unsigned SEQ_W    = 32,
    parameter int unsigned LEN_W    = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                rx_hdr_val,
    output logic                rx_hdr_rdy,
    input  logic [FLOWID_W-1:0] rx_hdr_flowid,
    input  logic [SEQ_W-1:0]    rx_hdr_seq,
    input  logic [SEQ_W-1:0]    rx_hdr_ack,
    input  logic                rx_hdr_ack_flag,
    input  logic [LEN_W-1:0]    rx_hdr_len,

    output logic                state_rd_req_val,
    input  logic                state_rd_req_rdy,
    output logic [FLOWID_W-1:0] state_rd_req_flowid,

    input  logic                state_rd_resp_val,
    output logic                state_rd_resp_rdy,
    input  logic [SEQ_W-1:0]    state_rd_resp_rcv_nxt,
    input  logic [SEQ_W-1:0]    state_rd_resp_snd_una,

    output logic                state_wr_req_val,
    input  logic                state_wr_req_rdy,
    output logic [FLOWID_W-1:0] state_wr_req_flowid,
    output logic [SEQ_W-1:0]    state_wr_req_rcv_nxt,
    output logic [SEQ_W-1:0]    state_wr_req_snd_una,

    output logic                rx_payload_val,
    input  logic                rx_payload_rdy,
    output logic [FLOWID_W-1:0] rx_payload_flowid,
    output logic [SEQ_W-1:0]    rx_payload_seq,
    output logic [LEN_W-1:0]    rx_payload_len,

    output logic                sched_ack_req_val,
    input  logic                sched_ack_req_rdy,
    output logic [FLOWID_W-1:0] sched_ack_req_flowid
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        WAIT_RESP,
        CALC,
        PAYLOAD_OUT,
        WRITEBACK,
        SCHED_NOTIFY
    } state_t;

    state_t state, state_nxt;

    logic [FLOWID_W-1:0] flowid_q;
    logic [SEQ_W-1:0]    seq_q;
    logic [SEQ_W-1:0]    ack_q;
    logic                ack_flag_q;
    logic [LEN_W-1:0]    len_q;
    logic [SEQ_W-1:0]    rcv_nxt_q;
    logic [SEQ_W-1:0]    snd_una_q;
    logic [SEQ_W-1:0]    new_rcv_nxt_q;
    logic [SEQ_W-1:0]    new_snd_una_q;

    logic                accept;
    logic                adv;
    logic [SEQ_W-1:0]    diff;
    logic [SEQ_W-1:0]    calc_rcv_nxt;
    logic [SEQ_W-1:0]    calc_snd_una;

    // Acceptance and ACK advance; a diff with MSB set (incl. exactly half range) is stale.
    always_comb begin
        accept       = (seq_q == rcv_nxt_q) && (len_q != '0);
        diff         = ack_q - snd_una_q;
        adv          = ack_flag_q && (diff != '0) && !diff[SEQ_W-1];
        calc_rcv_nxt = accept ? rcv_nxt_q + SEQ_W'(len_q) : rcv_nxt_q;
        calc_snd_una = adv ? ack_q : snd_una_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        rx_hdr_rdy        = 1'b0;
        state_rd_req_val  = 1'b0;
        state_rd_resp_rdy = 1'b0;
        rx_payload_val    = 1'b0;
        state_wr_req_val  = 1'b0;
        sched_ack_req_val = 1'b0;
        case (state)
            IDLE: begin
                rx_hdr_rdy = !rst;
                if (rx_hdr_val) state_nxt = RD_REQ;
            end
            RD_REQ: begin
                state_rd_req_val = 1'b1;
                if (state_rd_req_rdy) state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                state_rd_resp_rdy = 1'b1;
                if (state_rd_resp_val) state_nxt = CALC;
            end
            CALC: begin
                state_nxt = accept ? PAYLOAD_OUT : WRITEBACK;
            end
            PAYLOAD_OUT: begin
                rx_payload_val = 1'b1;
                if (rx_payload_rdy) state_nxt = WRITEBACK;
            end
            WRITEBACK: begin
                state_wr_req_val = 1'b1;
                if (state_wr_req_rdy) state_nxt = (len_q != '0) ? SCHED_NOTIFY : IDLE;
            end
            SCHED_NOTIFY: begin
                sched_ack_req_val = 1'b1;
                if (sched_ack_req_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Segment context captured at each handshake; held stable for the output phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flowid_q      <= '0;
            seq_q         <= '0;
            ack_q         <= '0;
            ack_flag_q    <= 1'b0;
            len_q         <= '0;
            rcv_nxt_q     <= '0;
            snd_una_q     <= '0;
            new_rcv_nxt_q <= '0;
            new_snd_una_q <= '0;
        end else begin
            if (state == IDLE && rx_hdr_val) begin
                flowid_q   <= rx_hdr_flowid;
                seq_q      <= rx_hdr_seq;
                ack_q      <= rx_hdr_ack;
                ack_flag_q <= rx_hdr_ack_flag;
                len_q      <= rx_hdr_len;
            end
            if (state == WAIT_RESP && state_rd_resp_val) begin
                rcv_nxt_q <= state_rd_resp_rcv_nxt;
                snd_una_q <= state_rd_resp_snd_una;
            end
            if (state == CALC) begin
                new_rcv_nxt_q <= calc_rcv_nxt;
                new_snd_una_q <= calc_snd_una;
            end
        end
    end

    assign state_rd_req_flowid  = flowid_q;
    assign state_wr_req_flowid  = flowid_q;
    assign state_wr_req_rcv_nxt = new_rcv_nxt_q;
    assign state_wr_req_snd_una = new_snd_una_q;
    assign rx_payload_flowid    = flowid_q;
    assign rx_payload_seq       = seq_q;
    assign rx_payload_len       = len_q;
    assign sched_ack_req_flowid = flowid_q;

endmodule

// File: tb/tb_tcp_rx_ctrl.sv
// Directed bench for tcp_rx_ctrl: walks each segment through every handshake,
// checking outputs, ordering, latency and stall stability against hand-computed values.
module tb_tcp_rx_ctrl;

    localparam int unsigned FLOWID_W = 8;
    localparam int unsigned SEQ_W    = 32;
    localparam int unsigned LEN_W    = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                rx_hdr_val;
    logic                rx_hdr_rdy;
    logic [FLOWID_W-1:0] rx_hdr_flowid;
    logic [SEQ_W-1:0]    rx_hdr_seq;
    logic [SEQ_W-1:0]    rx_hdr_ack;
    logic                rx_hdr_ack_flag;
    logic [LEN_W-1:0]    rx_hdr_len;
    logic                state_rd_req_val;
    logic                state_rd_req_rdy;
    logic [FLOWID_W-1:0] state_rd_req_flowid;
    logic                state_rd_resp_val;
    logic                state_rd_resp_rdy;
    logic [SEQ_W-1:0]    state_rd_resp_rcv_nxt;
    logic [SEQ_W-1:0]    state_rd_resp_snd_una;
    logic                state_wr_req_val;
    logic                state_wr_req_rdy;
    logic [FLOWID_W-1:0] state_wr_req_flowid;
    logic [SEQ_W-1:0]    state_wr_req_rcv_nxt;
    logic [SEQ_W-1:0]    state_wr_req_snd_una;
    logic                rx_payload_val;
    logic                rx_payload_rdy;
    logic [FLOWID_W-1:0] rx_payload_flowid;
    logic [SEQ_W-1:0]    rx_payload_seq;
    logic [LEN_W-1:0]    rx_payload_len;
    logic                sched_ack_req_val;
    logic                sched_ack_req_rdy;
    logic [FLOWID_W-1:0] sched_ack_req_flowid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tcp_rx_ctrl #(.FLOWID_W(FLOWID_W), .SEQ_W(SEQ_W), .LEN_W(LEN_W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rx_hdr_val            (rx_hdr_val),
        .rx_hdr_rdy            (rx_hdr_rdy),
        .rx_hdr_flowid         (rx_hdr_flowid),
        .rx_hdr_seq            (rx_hdr_seq),
        .rx_hdr_ack            (rx_hdr_ack),
        .rx_hdr_ack_flag       (rx_hdr_ack_flag),
        .rx_hdr_len            (rx_hdr_len),
        .state_rd_req_val      (state_rd_req_val),
        .state_rd_req_rdy      (state_rd_req_rdy),
        .state_rd_req_flowid   (state_rd_req_flowid),
        .state_rd_resp_val     (state_rd_resp_val),
        .state_rd_resp_rdy     (state_rd_resp_rdy),
        .state_rd_resp_rcv_nxt (state_rd_resp_rcv_nxt),
        .state_rd_resp_snd_una (state_rd_resp_snd_una),
        .state_wr_req_val      (state_wr_req_val),
        .state_wr_req_rdy      (state_wr_req_rdy),
        .state_wr_req_flowid   (state_wr_req_flowid),
        .state_wr_req_rcv_nxt  (state_wr_req_rcv_nxt),
        .state_wr_req_snd_una  (state_wr_req_snd_una),
        .rx_payload_val        (rx_payload_val),
        .rx_payload_rdy        (rx_payload_rdy),
        .rx_payload_flowid     (rx_payload_flowid),
        .rx_payload_seq        (rx_payload_seq),
        .rx_payload_len        (rx_payload_len),
        .sched_ack_req_val     (sched_ack_req_val),
        .sched_ack_req_rdy     (sched_ack_req_rdy),
        .sched_ack_req_flowid  (sched_ack_req_flowid)
    );

    typedef struct {
        logic [7:0]  flowid;
        logic [31:0] seq;
        logic [31:0] ack;
        logic        flag;
        logic [15:0] len;
        logic [31:0] rcv;
        logic [31:0] una;
        logic        exp_pay;
        logic [31:0] exp_rcv;
        logic [31:0] exp_una;
        logic        exp_ntf;
        int          stall;
        int          rstall;
        int          lat;
    } vec_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        cyc = 0;
        @(negedge clk);
        check("idle_hdr_rdy", 64'(rx_hdr_rdy), 64'd1);
        rx_hdr_val      = 1'b1;
        rx_hdr_flowid   = v.flowid;
        rx_hdr_seq      = v.seq;
        rx_hdr_ack      = v.ack;
        rx_hdr_ack_flag = v.flag;
        rx_hdr_len      = v.len;
        @(negedge clk); cyc++;
        rx_hdr_val    = 1'b0;
        rx_hdr_seq    = 32'hDEAD_BEEF;
        rx_hdr_len    = 16'hBEEF;
        check("rd_req_val", 64'(state_rd_req_val), 64'd1);
        check("rd_req_flowid", 64'(state_rd_req_flowid), 64'(v.flowid));
        check("hdr_rdy_busy", 64'(rx_hdr_rdy), 64'd0);
        state_rd_req_rdy = 1'b1;
        @(negedge clk); cyc++;
        state_rd_req_rdy = 1'b0;
        check("rd_req_drop", 64'(state_rd_req_val), 64'd0);
        for (int i = 0; i < v.rstall; i++) begin
            check("resp_rdy_stall", 64'(state_rd_resp_rdy), 64'd1);
            check("hdr_rdy_busy", 64'(rx_hdr_rdy), 64'd0);
            @(negedge clk); cyc++;
        end
        check("resp_rdy", 64'(state_rd_resp_rdy), 64'd1);
        state_rd_resp_val     = 1'b1;
        state_rd_resp_rcv_nxt = v.rcv;
        state_rd_resp_snd_una = v.una;
        @(negedge clk); cyc++;
        state_rd_resp_val     = 1'b0;
        state_rd_resp_rcv_nxt = 32'h5A5A_5A5A;
        state_rd_resp_snd_una = 32'hA5A5_A5A5;
        check("calc_quiet", 64'({state_rd_resp_rdy, rx_payload_val, state_wr_req_val, sched_ack_req_val}), 64'd0);
        @(negedge clk); cyc++;
        if (v.exp_pay) begin
            for (int i = 0; i < v.stall; i++) begin
                check("pay_val_stall", 64'(rx_payload_val), 64'd1);
                check("pay_seq_stall", 64'(rx_payload_seq), 64'(v.seq));
                check("pay_len_stall", 64'(rx_payload_len), 64'(v.len));
                check("hdr_rdy_busy", 64'(rx_hdr_rdy), 64'd0);
                @(negedge clk); cyc++;
            end
            check("pay_val", 64'(rx_payload_val), 64'd1);
            check("pay_flowid", 64'(rx_payload_flowid), 64'(v.flowid));
            check("pay_seq", 64'(rx_payload_seq), 64'(v.seq));
            check("pay_len", 64'(rx_payload_len), 64'(v.len));
            check("pay_no_wr", 64'(state_wr_req_val), 64'd0);
            rx_payload_rdy = 1'b1;
            @(negedge clk); cyc++;
            rx_payload_rdy = 1'b0;
        end
        check("no_payload", 64'(rx_payload_val), 64'd0);
        for (int i = 0; i < v.stall; i++) begin
            check("wr_val_stall", 64'(state_wr_req_val), 64'd1);
            check("wr_rcv_stall", 64'(state_wr_req_rcv_nxt), 64'(v.exp_rcv));
            check("wr_una_stall", 64'(state_wr_req_snd_una), 64'(v.exp_una));
            check("hdr_rdy_busy", 64'(rx_hdr_rdy), 64'd0);
            @(negedge clk); cyc++;
        end
        check("wr_val", 64'(state_wr_req_val), 64'd1);
        check("wr_flowid", 64'(state_wr_req_flowid), 64'(v.flowid));
        check("wr_rcv_nxt", 64'(state_wr_req_rcv_nxt), 64'(v.exp_rcv));
        check("wr_snd_una", 64'(state_wr_req_snd_una), 64'(v.exp_una));
        check("wr_no_sched", 64'(sched_ack_req_val), 64'd0);
        state_wr_req_rdy = 1'b1;
        @(negedge clk); cyc++;
        state_wr_req_rdy = 1'b0;
        check("wr_drop", 64'(state_wr_req_val), 64'd0);
        if (v.exp_ntf) begin
            for (int i = 0; i < v.stall; i++) begin
                check("sched_val_stall", 64'(sched_ack_req_val), 64'd1);
                check("sched_flowid_stall", 64'(sched_ack_req_flowid), 64'(v.flowid));
                check("hdr_rdy_busy", 64'(rx_hdr_rdy), 64'd0);
                @(negedge clk); cyc++;
            end
            check("sched_val", 64'(sched_ack_req_val), 64'd1);
            check("sched_flowid", 64'(sched_ack_req_flowid), 64'(v.flowid));
            sched_ack_req_rdy = 1'b1;
            @(negedge clk); cyc++;
            sched_ack_req_rdy = 1'b0;
        end
        check("sched_quiet", 64'(sched_ack_req_val), 64'd0);
        check("back_idle", 64'(rx_hdr_rdy), 64'd1);
        if (v.lat != 0) check("latency", 64'(cyc), 64'(v.lat));
    endtask

    vec_t vecs[$];

    initial begin
        rst                   = 1'b1;
        rx_hdr_val            = 1'b0;
        rx_hdr_flowid         = '0;
        rx_hdr_seq            = '0;
        rx_hdr_ack            = '0;
        rx_hdr_ack_flag       = 1'b0;
        rx_hdr_len            = '0;
        state_rd_req_rdy      = 1'b0;
        state_rd_resp_val     = 1'b0;
        state_rd_resp_rcv_nxt = '0;
        state_rd_resp_snd_una = '0;
        state_wr_req_rdy      = 1'b0;
        rx_payload_rdy        = 1'b0;
        sched_ack_req_rdy     = 1'b0;

        // flowid seq ack flag len | rcv una | pay exp_rcv exp_una ntf | stall rstall lat
        vecs.push_back('{8'd3, 32'd1000, 32'd600, 1'b1, 16'd100, 32'd1000, 32'd500,
                         1'b1, 32'd1100, 32'd600, 1'b1, 0, 0, 7});
        vecs.push_back('{8'd4, 32'd1200, 32'd500, 1'b1, 16'd50, 32'd1000, 32'd500,
                         1'b0, 32'd1000, 32'd500, 1'b1, 0, 0, 6});
        vecs.push_back('{8'd5, 32'd1000, 32'd550, 1'b1, 16'd0, 32'd1000, 32'd600,
                         1'b0, 32'd1000, 32'd600, 1'b0, 0, 0, 5});
        vecs.push_back('{8'd6, 32'hFFFF_FFF0, 32'h10, 1'b1, 16'h20, 32'hFFFF_FFF0, 32'hFFFF_FFFF,
                         1'b1, 32'h10, 32'h10, 1'b1, 0, 0, 7});
        vecs.push_back('{8'd7, 32'd7, 32'h8000_0000, 1'b1, 16'd0, 32'd7, 32'd0,
                         1'b0, 32'd7, 32'd0, 1'b0, 0, 0, 5});
        vecs.push_back('{8'd8, 32'd50, 32'd200, 1'b0, 16'd10, 32'd50, 32'd100,
                         1'b1, 32'd60, 32'd100, 1'b1, 0, 0, 7});
        vecs.push_back('{8'd9, 32'd20, 32'h7FFF_FFFF, 1'b1, 16'd0, 32'd20, 32'd0,
                         1'b0, 32'd20, 32'h7FFF_FFFF, 1'b0, 0, 0, 5});
        vecs.push_back('{8'd3, 32'd1000, 32'd600, 1'b1, 16'd100, 32'd1000, 32'd500,
                         1'b1, 32'd1100, 32'd600, 1'b1, 10, 5, 0});

        // Reset state: everything quiet, header not accepted while rst is high.
        repeat (2) @(negedge clk);
        check("rst_hdr_rdy", 64'(rx_hdr_rdy), 64'd0);
        check("rst_valids", 64'({state_rd_req_val, state_rd_resp_rdy, rx_payload_val,
                                  state_wr_req_val, sched_ack_req_val}), 64'd0);
        check("rst_wr_data", 64'({state_wr_req_rcv_nxt, state_wr_req_snd_una}), 64'd0);
        rst = 1'b0;

        foreach (vecs[k]) run_vec(vecs[k]);

        // Reset while presenting a payload descriptor.
        @(negedge clk);
        rx_hdr_val      = 1'b1;
        rx_hdr_flowid   = 8'd11;
        rx_hdr_seq      = 32'd300;
        rx_hdr_ack      = 32'd0;
        rx_hdr_ack_flag = 1'b0;
        rx_hdr_len      = 16'd40;
        @(negedge clk);
        rx_hdr_val       = 1'b0;
        state_rd_req_rdy = 1'b1;
        @(negedge clk);
        state_rd_req_rdy      = 1'b0;
        state_rd_resp_val     = 1'b1;
        state_rd_resp_rcv_nxt = 32'd300;
        state_rd_resp_snd_una = 32'd0;
        @(negedge clk);
        state_rd_resp_val = 1'b0;
        @(negedge clk);
        check("mid_pay_val", 64'(rx_payload_val), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valids", 64'({rx_payload_val, state_wr_req_val, sched_ack_req_val,
                                      state_rd_req_val, state_rd_resp_rdy}), 64'd0);
        check("mid_rst_hdr_rdy", 64'(rx_hdr_rdy), 64'd0);
        rx_payload_rdy    = 1'b1;
        state_wr_req_rdy  = 1'b1;
        sched_ack_req_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_hdr_rdy", 64'(rx_hdr_rdy), 64'd1);
            check("post_rst_no_wr", 64'({state_wr_req_val, sched_ack_req_val, rx_payload_val}), 64'd0);
        end
        rx_payload_rdy    = 1'b0;
        state_wr_req_rdy  = 1'b0;
        sched_ack_req_rdy = 1'b0;

        // Engine still works normally after the abandoned segment.
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcp_rx_ctrl.md
# tcp_rx_ctrl

Receive-side control engine for the slow-path TCP engine. It accepts one parsed inbound segment header at a time and reads the flow's state. It then decides in-order acceptance and ACK advancement, emits a payload descriptor for accepted data, writes the state back, and asks the TX scheduler to send an ACK. It sits between the RX header parser and the shared per-flow state memory, and is the receive counterpart of the scheduler-driven TX control engine.

## Interface
Parameters:
- FLOWID_W, 8, flow-ID width
- SEQ_W, 32, sequence/ack number width
- LEN_W, 16, payload length width

Ports:
- clk  in  1  clock
- rst  in  1  reset. Asynchronous, active-high (already decided).
- rx_hdr_val  in  1  inbound header valid
- rx_hdr_rdy  out  1  inbound header ready
- rx_hdr_flowid  in  FLOWID_W  flow of the segment
- rx_hdr_seq  in  SEQ_W  segment sequence number
- rx_hdr_ack  in  SEQ_W  segment ack number
- rx_hdr_ack_flag  in  1  ACK bit set
- rx_hdr_len  in  LEN_W  payload bytes
- state_rd_req_val / state_rd_req_rdy  out/in  1  flow-state read request handshake
- state_rd_req_flowid  out  FLOWID_W  flow to read
- state_rd_resp_val / state_rd_resp_rdy  in/out  1  read response handshake
- state_rd_resp_rcv_nxt, state_rd_resp_snd_una  in  SEQ_W  current state
- state_wr_req_val / state_wr_req_rdy  out/in  1  write-back handshake
- state_wr_req_flowid  out  FLOWID_W  flow to write
- state_wr_req_rcv_nxt, state_wr_req_snd_una  out  SEQ_W  next state
- rx_payload_val / rx_payload_rdy  out/in  1  accepted-data descriptor handshake
- rx_payload_flowid  out  FLOWID_W  flow of the data
- rx_payload_seq  out  SEQ_W  sequence number of the data
- rx_payload_len  out  LEN_W  length of the data
- sched_ack_req_val / sched_ack_req_rdy  out/in  1  ACK-request handshake to the TX scheduler
- sched_ack_req_flowid  out  FLOWID_W  flow needing an ACK

## Operation
- FSM states: IDLE, RD_REQ, WAIT_RESP, CALC, PAYLOAD_OUT, WRITEBACK, SCHED_NOTIFY.
- IDLE:
  - rx_hdr_rdy=1.
  - On rx_hdr_val, latch all header fields and go to RD_REQ.
- RD_REQ:
  - state_rd_req_val=1 with the latched flowid.
  - Go to WAIT_RESP when state_rd_req_rdy is high.
- WAIT_RESP:
  - state_rd_resp_rdy=1.
  - On state_rd_resp_val, latch rcv_nxt and snd_una and go to CALC.
- CALC (one cycle):
  - accept = (seq == rcv_nxt) && len != 0.
  - new_rcv_nxt = accept ? rcv_nxt + len (zero-extended, mod 2^SEQ_W) : rcv_nxt.
  - diff = ack - snd_una (mod 2^SEQ_W). adv = ack_flag && diff != 0 && diff[SEQ_W-1] == 0.
  - new_snd_una = adv ? ack : snd_una.
  - Register all results. Go to PAYLOAD_OUT if accept, else WRITEBACK.
- PAYLOAD_OUT:
  - rx_payload_val=1 with flowid, seq and len.
  - Go to WRITEBACK on rx_payload_rdy.
- WRITEBACK:
  - state_wr_req_val=1 with flowid, new_rcv_nxt and new_snd_una. The write is always issued, even when nothing changed.
  - On state_wr_req_rdy, go to SCHED_NOTIFY if len != 0, else IDLE.
- SCHED_NOTIFY:
  - sched_ack_req_val=1 with flowid.
  - Go to IDLE on sched_ack_req_rdy.
  - Out-of-order data therefore still produces a duplicate ACK request. Pure ACKs (len=0) produce none.
- Wrap-around: all sequence arithmetic is modulo 2^SEQ_W.
- Ack comparison:
  - A diff with MSB set is old/duplicate and is ignored.
  - diff == 2^(SEQ_W-1) is treated as old.

## Timing
- All valid/rdy outputs are combinational decodes of the state register. Every output valid is 0 outside its own state.
- Reset:
  - rst asynchronously forces IDLE and clears all latched registers to 0.
  - While rst is high, every output valid and rx_hdr_rdy is 0 (rx_hdr_rdy is gated with ~rst).
  - Reset mid-operation abandons the segment; no write-back or notify occurs.
- Data outputs are held stable while the corresponding valid is high and not yet accepted.
- A handshake completes on val && rdy at the rising clk edge.
- Latency:
  - Minimum with all rdy high and a same-cycle read response: 7 cycles from header accept to return to IDLE for accepted data.
  - The path is 5 cycles for a pure ACK.
- Throughput: one segment in flight. rx_hdr_rdy is low from the cycle after accept until IDLE.
- Any stalled downstream rdy holds the FSM in that state indefinitely, with valid held high.

## Test plan
- In-order data:
  - Stimulus: state rcv_nxt=1000, snd_una=500; header seq=1000, len=100, ack=600, ack_flag=1.
  - Required: payload (seq 1000, len 100), then write (rcv_nxt=1100, snd_una=600), then an ACK request, in that order.
- Out-of-order data:
  - Stimulus: rcv_nxt=1000; seq=1200, len=50.
  - Required: no payload; write with rcv_nxt=1000; ACK request issued.
- Pure old ACK:
  - Stimulus: snd_una=600; len=0, ack=550, ack_flag=1.
  - Required: write with snd_una=600; no payload; no ACK request; back in IDLE after 5 cycles.
- Wrap-around:
  - Stimulus: rcv_nxt=0xFFFF_FFF0, seq=0xFFFF_FFF0, len=0x20; snd_una=0xFFFF_FFFF, ack=0x10.
  - Required: rcv_nxt=0x0000_0010, snd_una=0x10.
- Backpressure:
  - Stimulus: hold rx_payload_rdy, state_wr_req_rdy and sched_ack_req_rdy low for 10 cycles each, and state_rd_resp_val low for 5 cycles.
  - Required: valids and data stay stable throughout; the final state is identical to the no-stall run; rx_hdr_rdy stays 0 throughout.
- Reset mid-operation:
  - Stimulus: assert rst while in PAYLOAD_OUT.
  - Required: all valids drop immediately; after release the FSM is in IDLE with rx_hdr_rdy=1 and no write-back is issued.
